// File: rtl/riscy_mem_pkg.sv
// riscy_mem_pkg: shared size encodings, LSU state enum and alignment check.
package riscy_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // Illegal size counts as a fault alongside true misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SIZE_ILLEGAL) ||
           (size == SIZE_HALF && addr_lo[0]) ||
           (size == SIZE_WORD && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
  import riscy_mem_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;

  always_comb begin
    sh          = size == SIZE_HALF ? {addr_lo[1], 4'b0} : {addr_lo, 3'b0};
    b           = 8'(word_in >> sh);
    h           = 16'(word_in >> sh);
    mask        = size == SIZE_HALF ? 32'h0000_FFFF << sh :
                  size == SIZE_BYTE ? 32'h0000_00FF << sh : '1;
    load_result = size == SIZE_BYTE ? {{24{~is_unsigned & b[7]}}, b} :
                  size == SIZE_HALF ? {{16{~is_unsigned & h[15]}}, h} : word_in;
    merged_word = (word_in & ~mask) | ((store_data << sh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding byte/half/word load-store adapter onto a word-indexed
// combinational-read memory port; sub-word stores use read-modify-write.
module load_store_unit
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqUnsigned,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [31:0]           reqData,
  output logic                  respValid,
  output logic [31:0]           respData,
  output logic                  respFault,
  output logic [31:0]           memAddress,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  output logic [31:0]           memDataOut,
  input  logic [31:0]           memDataIn
);

  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d, uns_q, uns_d;
  logic [1:0]    size_q, size_d, lo_q, lo_d;
  logic [31:0]   data_q, data_d;
  logic          ready_q, ready_d, rvalid_q, rvalid_d, rfault_q, rfault_d, re_q, re_d, we_q, we_d;
  logic [31:0]   rdata_q, rdata_d, maddr_q, maddr_d, mdout_q, mdout_d;
  logic          accept, fault;
  logic [31:0]   load_result, merged_word;

  assign accept = reqValid & ready_q;
  assign fault  = is_misaligned(reqSize, reqAddress[1:0]);

  lsu_lane_align u_align (
    .word_in     (memDataIn),
    .addr_lo     (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (data_q),
    .load_result (load_result),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rfault_q <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      mdout_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rfault_q <= rfault_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      re_q     <= re_d;
      we_q     <= we_d;
      mdout_q  <= mdout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    uns_d   = uns_q;
    size_d  = size_q;
    lo_d    = lo_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (accept) begin
        write_d = reqWrite;
        uns_d   = reqUnsigned;
        size_d  = reqSize;
        lo_d    = reqAddress[1:0];
        data_d  = reqData;
        cnt_d   = CW'(WAIT_CYCLES - 1);
        state_d = fault ? RESP : (reqWrite && reqSize == SIZE_WORD) ? WR : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next state so every port is a flop.
  always_comb begin
    ready_d  = state_d == IDLE;
    re_d     = state_d == RD_WAIT;
    we_d     = state_d == WR;
    rvalid_d = state_d == RESP;
    rfault_d = accept && fault;
    rdata_d  = (state_q == RD_WAIT && state_d == RESP) ? load_result : '0;
    maddr_d  = state_d == IDLE ? '0 : accept ? 32'(reqAddress >> 2) : maddr_q;
    mdout_d  = state_d == WR ? (state_q == IDLE ? reqData : merged_word) : '0;
  end

  assign reqReady       = ready_q;
  assign respValid      = rvalid_q;
  assign respData       = rdata_q;
  assign respFault      = rfault_q;
  assign memAddress     = maddr_q;
  assign memReadEnable  = re_q;
  assign memWriteEnable = we_q;
  assign memDataOut     = mdout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table against a WAIT_CYCLES=1 unit, plus hand sequences
// for WAIT_CYCLES=3 timing/backpressure and reset in the middle of a sub-word store.
module tb_load_store_unit;
  import riscy_mem_pkg::*;

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ef;
    int          lat;
    int          re;
    int          we;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        rw, ru, rv1, rv3;
  logic [1:0]  rs;
  logic [31:0] ra, rd;
  logic        rdy1, rsv1, rsf1, re1, we1, rdy3, rsv3, rsf3, re3, we3;
  logic [31:0] rsd1, ma1, mo1, mi1, rsd3, ma3, mo3, mi3;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  int n_chk = 0;
  int n_fail = 0;
  int coinc = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .resetN(resetN), .reqValid(rv1), .reqReady(rdy1), .reqWrite(rw), .reqSize(rs),
    .reqUnsigned(ru), .reqAddress(ra), .reqData(rd), .respValid(rsv1), .respData(rsd1),
    .respFault(rsf1), .memAddress(ma1), .memReadEnable(re1), .memWriteEnable(we1),
    .memDataOut(mo1), .memDataIn(mi1)
  );

  load_store_unit #(.ADDR_WIDTH(32), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .resetN(resetN), .reqValid(rv3), .reqReady(rdy3), .reqWrite(rw), .reqSize(rs),
    .reqUnsigned(ru), .reqAddress(ra), .reqData(rd), .respValid(rsv3), .respData(rsd3),
    .respFault(rsf3), .memAddress(ma3), .memReadEnable(re3), .memWriteEnable(we3),
    .memDataOut(mo3), .memDataIn(mi3)
  );

  assign mi1 = mem1[ma1[7:0]];
  assign mi3 = mem3[ma3[7:0]];

  always @(posedge clk) begin
    if (we1) mem1[ma1[7:0]] <= mo1;
    if (we3) mem3[ma3[7:0]] <= mo3;
  end

  always @(negedge clk) if ((re1 & we1) | (re3 & we3)) coinc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run1(input vec_t v, output int lat, output int nre, output int nwe,
                      output logic [31:0] rdat, output logic rflt, output logic [31:0] addr);
    int n;
    n = 0;
    while (!rdy1 && n < 20) begin @(posedge clk); #1; n++; end
    rw = v.w; rs = v.s; ru = v.u; ra = v.a; rd = v.d; rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    lat = 1; nre = 0; nwe = 0; addr = ma1;
    while (!rsv1 && lat < 20) begin
      nre += re1 ? 1 : 0;
      nwe += we1 ? 1 : 0;
      @(posedge clk); #1;
      lat++;
    end
    rdat = rsd1;
    rflt = rsf1;
  endtask

  initial begin
    vec_t        vt [23];
    vec_t        lv;
    int          lat, nre, nwe, ren, resp_j, resp2, acc_e, j;
    logic [31:0] rdat, rdat2, addr;
    logic        rflt;

    vt[0]  = '{1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1};
    vt[1]  = '{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
    vt[2]  = '{1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1};
    vt[3]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0};
    vt[4]  = '{1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0,        32'h00000080, 1'b0, 2, 1, 0};
    vt[5]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h101, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0};
    vt[6]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h102, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0};
    vt[7]  = '{1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0};
    vt[8]  = '{1'b0, SIZE_HALF, 1'b1, 32'h100, 32'h0,        32'h00007F01, 1'b0, 2, 1, 0};
    vt[9]  = '{1'b0, SIZE_HALF, 1'b0, 32'h100, 32'h0,        32'h00007F01, 1'b0, 2, 1, 0};
    vt[10] = '{1'b0, SIZE_WORD, 1'b1, 32'h100, 32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0};
    vt[11] = '{1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h11223344, 32'h0,        1'b0, 2, 0, 1};
    vt[12] = '{1'b1, SIZE_HALF, 1'b0, 32'h102, 32'h5555ABCD, 32'h0,        1'b0, 3, 1, 1};
    vt[13] = '{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0,        32'hABCD3344, 1'b0, 2, 1, 0};
    vt[14] = '{1'b1, SIZE_BYTE, 1'b0, 32'h101, 32'h123456EE, 32'h0,        1'b0, 3, 1, 1};
    vt[15] = '{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0,        32'hABCDEE44, 1'b0, 2, 1, 0};
    vt[16] = '{1'b0, SIZE_WORD, 1'b0, 32'hC0000100, 32'h0,   32'hABCDEE44, 1'b0, 2, 1, 0};
    vt[17] = '{1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vt[18] = '{1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vt[19] = '{1'b0, 2'b11,     1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vt[20] = '{1'b1, SIZE_WORD, 1'b0, 32'h101, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0};
    vt[21] = '{1'b1, SIZE_HALF, 1'b0, 32'h103, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0};
    vt[22] = '{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0,        32'hABCDEE44, 1'b0, 2, 1, 0};

    rv1 = 1'b0; rv3 = 1'b0; rw = 1'b0; rs = 2'b00; ru = 1'b0; ra = '0; rd = '0;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready", rdy1, 1'b0);
    chk1("rst_resp_valid", rsv1, 1'b0);
    chk("rst_resp_data", rsd1, 32'h0);
    chk1("rst_resp_fault", rsf1, 1'b0);
    chk("rst_mem_addr", ma1, 32'h0);
    chk1("rst_re", re1, 1'b0);
    chk1("rst_we", we1, 1'b0);
    chk("rst_mem_dout", mo1, 32'h0);
    chk1("rst_ready3", rdy3, 1'b0);
    @(negedge clk) resetN = 1'b1;
    #1 chk1("rel_ready_before_edge", rdy1, 1'b0);
    @(posedge clk); #1;
    chk1("rel_ready_after_edge", rdy1, 1'b1);
    chk1("rel_ready3_after_edge", rdy3, 1'b1);

    for (int i = 0; i < 23; i++) begin
      run1(vt[i], lat, nre, nwe, rdat, rflt, addr);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_resp_data", i), rdat, vt[i].ed);
      chk1($sformatf("v%0d_resp_fault", i), rflt, vt[i].ef);
      chk($sformatf("v%0d_read_cycles", i), nre, vt[i].re);
      chk($sformatf("v%0d_write_cycles", i), nwe, vt[i].we);
      chk($sformatf("v%0d_mem_addr", i), addr, vt[i].a >> 2);
    end

    // WAIT_CYCLES=3: seed a word, then load it with reqValid held high throughout.
    rw = 1'b1; rs = SIZE_WORD; ru = 1'b0; ra = 32'h20; rd = 32'hCAFEF00D; rv3 = 1'b1;
    @(posedge clk); #1;
    rv3 = 1'b0;
    j = 0;
    while (!rsv3 && j < 20) begin @(posedge clk); #1; j++; end
    chk1("w3_store_resp", rsv3, 1'b1);
    chk1("w3_store_fault", rsf3, 1'b0);
    @(posedge clk); #1;
    chk1("w3_ready_after_resp", rdy3, 1'b1);
    rw = 1'b0; rv3 = 1'b1;
    @(posedge clk); #1;
    ren = 0; resp_j = -1; resp2 = -1; acc_e = -1; rdat = '0; rdat2 = '0;
    for (int k = 0; k < 12; k++) begin
      if (acc_e < 0) ren += re3 ? 1 : 0;
      if (rsv3) begin
        if (resp_j < 0) begin resp_j = k; rdat = rsd3; end
        else if (resp2 < 0) begin resp2 = k; rdat2 = rsd3; end
      end
      if (rdy3 && rv3 && acc_e < 0) acc_e = k + 1;
      if (k == acc_e) rv3 = 1'b0;
      @(posedge clk); #1;
    end
    rv3 = 1'b0;
    chk("w3_read_cycles", ren, 3);
    chk("w3_resp_cycle", resp_j, 3);
    chk("w3_resp_data", rdat, 32'hCAFEF00D);
    chk("w3_second_accept_edge", acc_e, 5);
    chk("w3_second_resp_cycle", resp2, 8);
    chk("w3_second_resp_data", rdat2, 32'hCAFEF00D);

    // Reset while a byte store sits in RD_WAIT.
    rw = 1'b1; rs = SIZE_BYTE; ru = 1'b0; ra = 32'h100; rd = 32'h00000099; rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    chk1("mr_re_before_reset", re1, 1'b1);
    resetN = 1'b0;
    #1;
    chk1("mr_re_dropped", re1, 1'b0);
    chk1("mr_we_dropped", we1, 1'b0);
    chk1("mr_ready_low", rdy1, 1'b0);
    ren = 0;
    repeat (2) begin @(posedge clk); #1; ren += (rsv1 | we1) ? 1 : 0; end
    @(negedge clk) resetN = 1'b1;
    #1 chk1("mr_ready_before_edge", rdy1, 1'b0);
    @(posedge clk); #1;
    chk1("mr_ready_after_edge", rdy1, 1'b1);
    repeat (3) begin ren += (rsv1 | we1 | re1) ? 1 : 0; @(posedge clk); #1; end
    chk("mr_no_activity", ren, 0);
    chk("mr_mem_unchanged", mem1[8'h40], 32'hABCDEE44);
    lv = vt[22];
    run1(lv, lat, nre, nwe, rdat, rflt, addr);
    chk("mr_reload_data", rdat, 32'hABCDEE44);
    chk("mr_reload_latency", lat, 2);

    chk("no_coincident_enables", coinc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the processor's memory stage and the main memory module. Accepts one load/store request at a time over a valid/ready handshake and converts byte addresses to word addresses. Stores: byte, half and word, using read-modify-write for sub-word stores. Loads: byte, half and word, with sign or zero extension. Drives the memory's word-indexed, 32-bit, combinational-read port, never asserting read and write together.

## Interface
- ADDR_WIDTH, 32, byte-address width of requests
- WAIT_CYCLES, 1, cycles memReadEnable is held before read data is sampled (≥1)
- clk  in  1  clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit idle, request accepted when reqValid & reqReady
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- reqUnsigned  in  1  zero-extend loads (ignored for stores/word)
- reqAddress  in  ADDR_WIDTH  byte address
- reqData  in  32  store data, right-aligned
- respValid  out  1  one-cycle completion pulse
- respData  out  32  extended load data; 0 for stores and faults
- respFault  out  1  valid with respValid; misaligned or illegal size
- memAddress  out  32  word index = reqAddress >> 2
- memReadEnable  out  1  to memory readEnable
- memWriteEnable  out  1  to memory writeEnable
- memDataOut  out  32  to memory dataIn
- memDataIn  in  32  from memory dataOut

## Operation
- FSM states: IDLE, RD_WAIT, WR, RESP.
- IDLE: reqReady = 1. On handshake, latch the request and check it:
  - fault if reqSize = 11, or half with addr[0] ≠ 0, or word with addr[1:0] ≠ 0
  - fault → RESP with respFault = 1; no memory enable is ever asserted
  - load, or sub-word store → RD_WAIT
  - word store → WR
- RD_WAIT: memReadEnable = 1 for WAIT_CYCLES cycles, counted by a down-counter. memDataIn is sampled on the last cycle.
  - load → extract lane, extend, → RESP
  - sub-word store → merge reqData into the sampled word, → WR
- WR: memWriteEnable = 1, memReadEnable = 0, memDataOut = full or merged word, for exactly one cycle → RESP.
- RESP: respValid = 1 for one cycle, reqReady = 0 → IDLE. There is no response backpressure.
- Lanes are little-endian.
  - Byte lane = addr[1:0], bits [8·lane+7 : 8·lane].
  - Half lane = addr[1], bits [16·addr[1]+15 : 16·addr[1]].
  - Loads sign-extend unless reqUnsigned. Sub-word stores replace only the addressed lane.
- memAddress is held stable from the cycle after accept through RESP. It is 0 in IDLE.
- memReadEnable and memWriteEnable are never high in the same cycle.
- Upper address bits beyond the word index are passed unchanged; no range check.

## Timing
- Accept at edge T. All outputs are registered.
- Word or sub-word load: RD_WAIT T+1..T+W, respValid at T+W+1 (W = WAIT_CYCLES).
- Word store: WR at T+1, respValid at T+2.
- Sub-word store: RD_WAIT T+1..T+W, WR T+W+1, respValid T+W+2.
- Fault: respValid with respFault at T+1.
- Back-to-back: the earliest next accept is the cycle after RESP. reqReady rises at T_resp+1.
- Reset values (resetN low, asynchronous):
  - state = IDLE
  - reqReady = 0; rises to 1 on the first clk edge with resetN high
  - respValid, respData, respFault = 0
  - memAddress, memDataOut = 0; memReadEnable, memWriteEnable = 0
- Reset mid-transaction: enables drop immediately and the transaction is discarded. No respValid is produced. A partially completed sub-word store never writes.
- reqValid while busy: ignored, no latch. Request fields need only be valid in the accept cycle.

## Structure
- Package riscy_mem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - the FSM state enum
  - the misalignment-check function
- Sub-module lsu_lane_align (combinational) handles load extract/extend and store merge. Inputs: word, addr[1:0], size, unsigned, storeData. Outputs: loadResult, mergedWord.
- Top: FSM, wait counter, request latch, output registers.

## Test plan
- Word store then load, WAIT_CYCLES = 1: store 0xDEADBEEF @0x100 → memWriteEnable at T+1 with memAddress 0x40; load @0x100 → respData 0xDEADBEEF at T+2, respFault 0.
- Byte loads, memory word 0x80FF7F01 @0x40: signed byte @0x103 → 0xFFFFFF80; unsigned byte @0x103 → 0x00000080; signed byte @0x101 → 0x0000007F.
- Half store RMW: word 0x11223344 @0x40, store half 0xABCD @0x102 → one read, then write 0xABCD3344. Read and write enables are never coincident.
- Faults: word load @0x102, half load @0x101, size 11 → respFault = 1 and respData = 0 at T+1; memory enables stay 0 throughout.
- WAIT_CYCLES = 3 word load → memReadEnable high exactly 3 cycles, respValid at T+4; reqValid held high during busy → no second accept until T+5.
- Reset asserted mid sub-word store (during RD_WAIT) → enables 0 immediately, no respValid, memory word unchanged, reqReady = 1 one edge after release.
